// File: rtl/fou_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : fou_scheduler_if
// Purpose  : Handshake bundle between the FOU scheduler and the shared
//            trapezoid membership evaluator.
// Signals  : mf_req  - scheduler requests an evaluation
//            mf_sel  - trapezoid index 0..11 under evaluation
//            mf_x    - crisp value to evaluate
//            mf_ack  - evaluator result valid
//            mf_mu   - membership degree returned by the evaluator
// Modports : master (scheduler side), slave (evaluator side)
// Revision : 1.0 - initial release
// ============================================================================
interface fou_scheduler_if;
  logic       mf_req;
  logic [3:0] mf_sel;
  logic [7:0] mf_x;
  logic       mf_ack;
  logic [7:0] mf_mu;

  modport master (output mf_req, output mf_sel, output mf_x,
                  input  mf_ack, input  mf_mu);
  modport slave  (input  mf_req, input  mf_sel, input  mf_x,
                  output mf_ack, output mf_mu);
endinterface
`default_nettype wire

// File: rtl/fou_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fou_scheduler
// Purpose  : Sequences the twelve FOU upper/lower membership evaluations of
//            one frame through a single shared trapezoid evaluator, collects
//            the degrees in a work bank and publishes them to a result bank
//            once the frame completes.
// Ports    : clk, RESET (async, active low)
//            EN_SCLK, start         - frame request, gated by sample enable
//            Input_01, Input_02     - crisp inputs (latched at frame start)
//            mf (master modport)    - evaluator handshake
//            busy, done, err        - status (err is sticky until reset)
//            Ativo_UP               - nonzero flags of the six UP degrees
//            rd_idx / rd_data       - combinational result bank read
// Options  : FOU_SKIP_LOW_EN - skip a LOW evaluation whose UP degree is zero
// Revision : 1.0 - initial release
// ============================================================================
module fou_scheduler #(
  parameter int ACK_TIMEOUT = 15
) (
  input  wire logic        clk,
  input  wire logic        RESET,
  input  wire logic        EN_SCLK,
  input  wire logic        start,
  input  wire logic [7:0]  Input_01,
  input  wire logic [7:0]  Input_02,
  fou_scheduler_if.master  mf,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [5:0]       Ativo_UP,
  input  wire logic [3:0]  rd_idx,
  output logic [7:0]       rd_data
);

  localparam logic [3:0] c_LAST_K   = 4'd11;
  // The entry times out on the edge where the counter would reach ACK_TIMEOUT.
  localparam logic [7:0] c_TO_LAST  = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  in1_q, in2_q;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic [7:0]  work_q [12];
  logic [7:0]  bank_q [12];

  logic        in_load;
  logic        wr_en;
  logic [7:0]  wr_val;
  logic        bank_load;
  logic        entry_done;
  logic        skip;

`ifdef FOU_SKIP_LOW_EN
  // A LOW entry (odd k) is pointless when its UP degree came back zero.
  assign skip = (state_q == S_REQ) && k_q[0] && (work_q[k_q - 4'd1] == 8'd0);
`else
  assign skip = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    wait_d     = wait_q;
    err_d      = err_q;
    done_d     = 1'b0;
    in_load    = 1'b0;
    wr_en      = 1'b0;
    wr_val     = 8'd0;
    bank_load  = 1'b0;
    entry_done = 1'b0;
    mf.mf_req  = 1'b0;
    mf.mf_sel  = 4'd0;
    mf.mf_x    = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (start && EN_SCLK) begin
          state_d = S_REQ;
          k_d     = 4'd0;
          wait_d  = 8'd0;
          in_load = 1'b1;
        end
      end

      S_REQ: begin
        mf.mf_sel = k_q;
        mf.mf_x   = (k_q < 4'd6) ? in1_q : in2_q;
        if (skip) begin
          wr_en      = 1'b1;
          entry_done = 1'b1;
        end else begin
          mf.mf_req = 1'b1;
          if (mf.mf_ack) begin
            wr_en      = 1'b1;
            wr_val     = mf.mf_mu;
            entry_done = 1'b1;
          end else if (wait_q == c_TO_LAST) begin
            wr_en      = 1'b1;
            err_d      = 1'b1;
            entry_done = 1'b1;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        if (entry_done) begin
          wait_d = 8'd0;
          if (k_q == c_LAST_K) begin
            state_d = S_DONE;
            k_d     = 4'd0;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end

      S_DONE: begin
        bank_load = 1'b1;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      k_q     <= 4'd0;
      wait_q  <= 8'd0;
      in1_q   <= 8'd0;
      in2_q   <= 8'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 12; i++) begin
        work_q[i] <= 8'd0;
        bank_q[i] <= 8'd0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      done_q  <= done_d;
      if (in_load) begin
        in1_q <= Input_01;
        in2_q <= Input_02;
      end
      if (wr_en) begin
        work_q[k_q] <= wr_val;
      end
      if (bank_load) begin
        for (int i = 0; i < 12; i++) begin
          bank_q[i] <= work_q[i];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Status and result outputs
  // --------------------------------------------------------------------------
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign rd_data = (rd_idx < 4'd12) ? bank_q[rd_idx] : 8'd0;

  // UP degrees live at even indices; FOU_1_UP maps to the MSB.
  for (genvar i = 0; i < 6; i++) begin : g_ativo
    assign Ativo_UP[5-i] = |bank_q[2*i];
  end

endmodule
`default_nettype wire

// File: tb/tb_fou_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fou_scheduler
// Purpose  : Directed self-checking bench for fou_scheduler (ACK_TIMEOUT=4).
//            A behavioural evaluator answers mf_mu = 8*mf_sel+1 unless the
//            index is masked to zero, and can withhold mf_ack for one index.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fou_scheduler;

  logic        clk = 1'b0;
  logic        RESET;
  logic        EN_SCLK;
  logic        start;
  logic [7:0]  in1, in2;
  logic        busy, done, err;
  logic [5:0]  ativo;
  logic [3:0]  rd_idx;
  logic [7:0]  rd_data;

  int          checks   = 0;
  int          failures = 0;

  logic        ack_en;
  logic        hold_en;
  logic [3:0]  hold_k;
  logic [15:0] mask;

  always #5 clk = ~clk;

  fou_scheduler_if mfif ();

  assign mfif.mf_ack = ack_en && !(hold_en && (mfif.mf_sel == hold_k));
  assign mfif.mf_mu  = mask[mfif.mf_sel] ? 8'd0 : ({mfif.mf_sel, 3'b000} + 8'd1);

  fou_scheduler #(.ACK_TIMEOUT(4)) dut (
    .clk      (clk),
    .RESET    (RESET),
    .EN_SCLK  (EN_SCLK),
    .start    (start),
    .Input_01 (in1),
    .Input_02 (in2),
    .mf       (mfif),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .Ativo_UP (ativo),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data)
  );

  // Drive a start pulse sampled at the next rising edge; returns #1 after it.
  task automatic start_frame(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in1 = a; in2 = b; start = 1'b1; EN_SCLK = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts rising edges after the start edge until done is seen; -1 if never.
  task automatic wait_done(input int lim, output int edges);
    bit seen = 0;
    edges = 0;
    while (edges < lim && !seen) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) edges = -1;
  endtask

  task automatic test_reset();
    RESET = 1'b0; EN_SCLK = 1'b0; start = 1'b0; in1 = 8'd0; in2 = 8'd0;
    ack_en = 1'b1; hold_en = 1'b0; hold_k = 4'd0; mask = 16'd0; rd_idx = 4'd0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err); end
    checks++; if (mfif.mf_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", mfif.mf_req); end
    checks++; if (ativo !== 6'd0) begin failures++; $display("FAIL rst_ativo got=%b exp=000000", ativo); end
    checks++; if (rd_data !== 8'd0) begin failures++; $display("FAIL rst_rd got=%0d exp=0", rd_data); end
    RESET = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame();
    int n;
    int e = -1;
    logic [7:0] exp;
    mask = 16'd0; ack_en = 1'b1; hold_en = 1'b0;
    start_frame(8'd60, 8'd200);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL frame_busy got=%0b exp=1", busy); end
    checks++; if (mfif.mf_req !== 1'b1) begin failures++; $display("FAIL frame_req got=%0b exp=1", mfif.mf_req); end
    checks++; if (mfif.mf_x !== 8'd60) begin failures++; $display("FAIL frame_x0 got=%0d exp=60", mfif.mf_x); end
    for (n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 6) begin
        checks++; if (mfif.mf_sel !== 4'd6) begin failures++; $display("FAIL frame_sel6 got=%0d exp=6", mfif.mf_sel); end
        checks++; if (mfif.mf_x !== 8'd200) begin failures++; $display("FAIL frame_x6 got=%0d exp=200", mfif.mf_x); end
      end
      if (done) begin e = n; break; end
    end
    checks++; if (e !== 13) begin failures++; $display("FAIL frame_latency got=%0d exp=13", e); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL frame_done_pulse got=%0b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL frame_idle got=%0b exp=0", busy); end
    for (int k = 0; k < 16; k++) begin
      rd_idx = 4'(k);
      #1;
      exp = (k >= 12) ? 8'd0 : 8'(8 * k + 1);
      checks++; if (rd_data !== exp) begin failures++; $display("FAIL frame_bank[%0d] got=%0d exp=%0d", k, rd_data, exp); end
    end
    checks++; if (ativo !== 6'b111111) begin failures++; $display("FAIL frame_ativo got=%b exp=111111", ativo); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL frame_err got=%0b exp=0", err); end
  endtask

  task automatic test_back_to_back();
    int e;
    logic [7:0] exp;
    mask = 16'd0;
    start_frame(8'd10, 8'd20);
    wait_done(40, e);
    checks++; if (e !== 13) begin failures++; $display("FAIL b2b_first got=%0d exp=13", e); end
    // Restart in the very cycle done is high.
    mask = 16'h0101; in1 = 8'd33; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%0b exp=1", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done got=%0b exp=0", done); end
    checks++; if (mfif.mf_x !== 8'd33) begin failures++; $display("FAIL b2b_x got=%0d exp=33", mfif.mf_x); end
    checks++; if (ativo !== 6'b111111) begin failures++; $display("FAIL b2b_hold_ativo got=%b exp=111111", ativo); end
    wait_done(40, e);
    checks++; if (e !== 13) begin failures++; $display("FAIL b2b_second got=%0d exp=13", e); end
    for (int k = 0; k < 12; k++) begin
      rd_idx = 4'(k);
      #1;
      exp = (k == 0 || k == 8) ? 8'd0 : 8'(8 * k + 1);
      checks++; if (rd_data !== exp) begin failures++; $display("FAIL b2b_bank[%0d] got=%0d exp=%0d", k, rd_data, exp); end
    end
    checks++; if (ativo !== 6'b011101) begin failures++; $display("FAIL b2b_ativo got=%b exp=011101", ativo); end
    mask = 16'd0;
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    @(negedge clk);
    EN_SCLK = 1'b0; start = 1'b1; in1 = 8'd77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_en_busy got=%0b exp=0", busy); end
    end
    start = 1'b0; EN_SCLK = 1'b1;
    start_frame(8'd60, 8'd200);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
      if (i == 1) begin in1 = 8'd99; start = 1'b1; end
      if (i == 2) begin
        start = 1'b0;
        checks++; if (mfif.mf_sel !== 4'd3) begin failures++; $display("FAIL ign_sel got=%0d exp=3", mfif.mf_sel); end
        checks++; if (mfif.mf_x !== 8'd60) begin failures++; $display("FAIL ign_x got=%0d exp=60", mfif.mf_x); end
      end
    end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_end_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_timeout();
    int e = -1;
    mask = 16'd0; hold_k = 4'd3; hold_en = 1'b1;
    start_frame(8'd60, 8'd200);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 3 || n == 6) begin
        checks++; if (mfif.mf_sel !== 4'd3) begin failures++; $display("FAIL to_sel_e%0d got=%0d exp=3", n, mfif.mf_sel); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_err_e%0d got=%0b exp=0", n, err); end
      end
      if (n == 7) begin
        checks++; if (mfif.mf_sel !== 4'd4) begin failures++; $display("FAIL to_sel_e7 got=%0d exp=4", mfif.mf_sel); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err_e7 got=%0b exp=1", err); end
      end
      if (done) begin e = n; break; end
    end
    hold_en = 1'b0;
    checks++; if (e !== 16) begin failures++; $display("FAIL to_latency got=%0d exp=16", e); end
    rd_idx = 4'd3; #1;
    checks++; if (rd_data !== 8'd0) begin failures++; $display("FAIL to_bank3 got=%0d exp=0", rd_data); end
    rd_idx = 4'd2; #1;
    checks++; if (rd_data !== 8'd17) begin failures++; $display("FAIL to_bank2 got=%0d exp=17", rd_data); end
    rd_idx = 4'd4; #1;
    checks++; if (rd_data !== 8'd33) begin failures++; $display("FAIL to_bank4 got=%0d exp=33", rd_data); end
    start_frame(8'd60, 8'd200);
    wait_done(40, e);
    checks++; if (e !== 13) begin failures++; $display("FAIL to_next_latency got=%0d exp=13", e); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%0b exp=1", err); end
  endtask

  task automatic test_reset_midframe();
    int e;
    logic [7:0] exp;
    start_frame(8'd60, 8'd200);
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++; if (mfif.mf_sel !== 4'd7) begin failures++; $display("FAIL rm_sel got=%0d exp=7", mfif.mf_sel); end
    #2 RESET = 1'b0;
    #1;
    checks++; if (mfif.mf_req !== 1'b0) begin failures++; $display("FAIL rm_req got=%0b exp=0", mfif.mf_req); end
    checks++; if (mfif.mf_sel !== 4'd0) begin failures++; $display("FAIL rm_sel0 got=%0d exp=0", mfif.mf_sel); end
    checks++; if (mfif.mf_x !== 8'd0) begin failures++; $display("FAIL rm_x got=%0d exp=0", mfif.mf_x); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%0b exp=0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rm_err got=%0b exp=0", err); end
    checks++; if (ativo !== 6'd0) begin failures++; $display("FAIL rm_ativo got=%b exp=000000", ativo); end
    rd_idx = 4'd0; #1;
    checks++; if (rd_data !== 8'd0) begin failures++; $display("FAIL rm_bank0 got=%0d exp=0", rd_data); end
    repeat (2) @(negedge clk);
    RESET = 1'b1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rm_done got=%0b exp=0", done); end
    start_frame(8'd60, 8'd200);
    wait_done(40, e);
    checks++; if (e !== 13) begin failures++; $display("FAIL rm_latency got=%0d exp=13", e); end
    for (int k = 0; k < 12; k++) begin
      rd_idx = 4'(k);
      #1;
      exp = 8'(8 * k + 1);
      checks++; if (rd_data !== exp) begin failures++; $display("FAIL rm_bank[%0d] got=%0d exp=%0d", k, rd_data, exp); end
    end
    checks++; if (ativo !== 6'b111111) begin failures++; $display("FAIL rm_ativo2 got=%b exp=111111", ativo); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rm_err2 got=%0b exp=0", err); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_ignore_start();
    test_timeout();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
